// File: rtl/plan_act.sv
// plan_act: three-stage piecewise-linear sigmoid/tanh activation with a
// valid/ready stream interface and a saturating count of saturated samples.
module plan_act #(
  parameter int IN_W     = 32,
  parameter int IN_FRAC  = 24,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 12,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             sat_clr
);

  localparam int SHIFT = IN_FRAC - OUT_FRAC;

  localparam logic [IN_W-1:0]  IN_LSB   = {{(IN_W-1){1'b0}}, 1'b1};
  localparam logic [IN_W-1:0]  MAG_MAX  = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0]  TANH_LIM = {2'b01, {(IN_W-2){1'b0}}};
  localparam logic [IN_W-1:0]  BP_LO    = IN_LSB << IN_FRAC;
  localparam logic [IN_W-1:0]  BP_MID   = {{(IN_W-5){1'b0}}, 5'd19} << (IN_FRAC - 3);
  localparam logic [IN_W-1:0]  BP_HI    = {{(IN_W-3){1'b0}}, 3'd5} << IN_FRAC;

  localparam logic [OUT_W-1:0] Y_ONE    = {{(OUT_W-1){1'b0}}, 1'b1} << OUT_FRAC;
  localparam logic [OUT_W-1:0] Y_SEG0   = {{(OUT_W-1){1'b0}}, 1'b1} << (OUT_FRAC - 1);
  localparam logic [OUT_W-1:0] Y_SEG1   = {{(OUT_W-3){1'b0}}, 3'd5} << (OUT_FRAC - 3);
  localparam logic [OUT_W-1:0] Y_SEG2   = {{(OUT_W-5){1'b0}}, 5'd27} << (OUT_FRAC - 5);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             en_s;
  logic             sign_s;
  logic [IN_W-1:0]  mag_s;
  logic [IN_W-1:0]  a_s;
  logic [OUT_W-1:0] y_s;
  logic             sat_s;
  logic [OUT_W-1:0] sym_s;
  logic [OUT_W-1:0] res_s;

  logic             v1_r, sign1_r, mode1_r;
  logic [IN_W-1:0]  a1_r;
  logic             v2_r, sign2_r, mode2_r, sat2_r;
  logic [OUT_W-1:0] y2_r;

  assign en_s     = !out_valid || out_ready;
  assign in_ready = en_s;

  // S1 next state: magnitude, doubled for tanh, clamped to the positive range
  always_comb begin
    sign_s = in_data[IN_W-1];
    if (sign_s) begin
      mag_s = ~in_data + IN_LSB;
    end else begin
      mag_s = in_data;
    end
    if (in_mode) begin
      if (mag_s >= TANH_LIM) begin
        a_s = MAG_MAX;
      end else begin
        a_s = {mag_s[IN_W-2:0], 1'b0};
      end
    end else begin
      if (mag_s > MAG_MAX) begin
        a_s = MAG_MAX;
      end else begin
        a_s = mag_s;
      end
    end
  end

  // S2 next state: segment select; each breakpoint belongs to the upper segment
  always_comb begin
    sat_s = 1'b0;
    y_s   = Y_ONE;
    if (a1_r < BP_LO) begin
      y_s = Y_SEG0 + OUT_W'(a1_r >> (SHIFT + 2));
    end else if (a1_r < BP_MID) begin
      y_s = Y_SEG1 + OUT_W'(a1_r >> (SHIFT + 3));
    end else if (a1_r < BP_HI) begin
      y_s = Y_SEG2 + OUT_W'(a1_r >> (SHIFT + 5));
    end else begin
      y_s   = Y_ONE;
      sat_s = 1'b1;
    end
  end

  // S3 next state: mirror for negative inputs, then rescale for tanh
  always_comb begin
    if (sign2_r) begin
      sym_s = Y_ONE - y2_r;
    end else begin
      sym_s = y2_r;
    end
    if (mode2_r) begin
      res_s = {sym_s[OUT_W-2:0], 1'b0} - Y_ONE;
    end else begin
      res_s = sym_s;
    end
  end

  // Pipeline registers; every stage advances or holds on the shared enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r      <= 1'b0;
      sign1_r   <= 1'b0;
      mode1_r   <= 1'b0;
      a1_r      <= {IN_W{1'b0}};
      v2_r      <= 1'b0;
      sign2_r   <= 1'b0;
      mode2_r   <= 1'b0;
      sat2_r    <= 1'b0;
      y2_r      <= {OUT_W{1'b0}};
      out_valid <= 1'b0;
      out_data  <= {OUT_W{1'b0}};
    end else if (en_s) begin
      v1_r      <= in_valid;
      sign1_r   <= sign_s;
      mode1_r   <= in_mode;
      a1_r      <= a_s;
      v2_r      <= v1_r;
      sign2_r   <= sign1_r;
      mode2_r   <= mode1_r;
      sat2_r    <= sat_s;
      y2_r      <= y_s;
      out_valid <= v2_r;
      if (v2_r) begin
        out_data <= res_s;
      end
    end
  end

  // Saturation counter: clear wins over an increment, and it never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= {CNT_W{1'b0}};
    end else if (sat_clr) begin
      sat_cnt <= {CNT_W{1'b0}};
    end else if (en_s && v2_r && sat2_r && (sat_cnt != CNT_MAX)) begin
      sat_cnt <= sat_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_plan_act.sv
// Directed bench for plan_act: vector table streamed through the pipe plus
// hand sequences for latency, backpressure, reset, sat_clr and saturation.
module tb_plan_act;

  localparam int NV = 23;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        in_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [5:0]  sat_cnt;
  logic        sat_clr = 1'b0;

  int tests = 0;
  int fails = 0;
  int exp_sat = 0;
  logic [15:0] outq[$];

  typedef struct packed {
    logic        mode;
    logic [31:0] x;
    logic [15:0] exp;
    logic        sat;
  } vec_t;

  vec_t vecs [NV];
  vec_t bp [6];

  plan_act #(.IN_W(32), .IN_FRAC(24), .OUT_W(16), .OUT_FRAC(12), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sat_cnt(sat_cnt),
    .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) outq.push_back(out_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the sample is accepted.
  task automatic send(input logic m, input logic [31:0] x);
    int w = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = x;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("send_timeout", w, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int c = 0;
    while (outq.size() < n && c < 200) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("out_count", n, outq.size(), n);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0000, 16'h0800, 1'b0};
    vecs[1]  = '{1'b0, 32'h0100_0000, 16'h0C00, 1'b0};
    vecs[2]  = '{1'b0, 32'hFF00_0000, 16'h0400, 1'b0};
    vecs[3]  = '{1'b0, 32'h0300_0000, 16'h0F00, 1'b0};
    vecs[4]  = '{1'b0, 32'h0600_0000, 16'h1000, 1'b1};
    vecs[5]  = '{1'b0, 32'h8000_0000, 16'h0000, 1'b1};
    vecs[6]  = '{1'b0, 32'h0260_0000, 16'h0EB0, 1'b0};
    vecs[7]  = '{1'b1, 32'h0080_0000, 16'h0800, 1'b0};
    vecs[8]  = '{1'b1, 32'hFF80_0000, 16'hF800, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0000, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 32'h7FFF_FFFF, 16'h1000, 1'b1};
    vecs[11] = '{1'b0, 32'h0080_0000, 16'h0A00, 1'b0};
    vecs[12] = '{1'b1, 32'h0080_0000, 16'h0800, 1'b0};
    vecs[13] = '{1'b0, 32'h0080_0000, 16'h0A00, 1'b0};
    vecs[14] = '{1'b1, 32'h0080_0000, 16'h0800, 1'b0};
    vecs[15] = '{1'b0, 32'h04FF_FFFF, 16'h0FFF, 1'b0};
    vecs[16] = '{1'b0, 32'h0500_0000, 16'h1000, 1'b1};
    vecs[17] = '{1'b0, 32'h00FF_FFFF, 16'h0BFF, 1'b0};
    vecs[18] = '{1'b0, 32'h025F_FFFF, 16'h0EBF, 1'b0};
    vecs[19] = '{1'b1, 32'hC000_0000, 16'hF000, 1'b1};
    vecs[20] = '{1'b1, 32'h3FFF_FFFF, 16'h1000, 1'b1};
    vecs[21] = '{1'b1, 32'hFF00_0000, 16'hF400, 1'b0};
    vecs[22] = '{1'b0, 32'hFB00_0000, 16'h0000, 1'b1};

    bp[0] = '{1'b0, 32'h0000_0000, 16'h0800, 1'b0};
    bp[1] = '{1'b0, 32'h0100_0000, 16'h0C00, 1'b0};
    bp[2] = '{1'b0, 32'hFF00_0000, 16'h0400, 1'b0};
    bp[3] = '{1'b0, 32'h0300_0000, 16'h0F00, 1'b0};
    bp[4] = '{1'b1, 32'hFF00_0000, 16'hF400, 1'b0};
    bp[5] = '{1'b1, 32'hFF80_0000, 16'hF800, 1'b0};

    // Reset state
    tick(3);
    rst = 1'b0;
    check("rst_out_valid", 0, out_valid, 1'b0);
    check("rst_out_data", 0, out_data, 16'h0000);
    check("rst_sat_cnt", 0, sat_cnt, 6'd0);
    check("rst_in_ready", 0, in_ready, 1'b1);

    // Latency: result visible three cycles after the accept cycle
    send(1'b0, 32'h0000_0000);
    @(negedge clk);
    check("lat_valid", 1, out_valid, 1'b0);
    @(negedge clk);
    check("lat_valid", 2, out_valid, 1'b0);
    @(negedge clk);
    check("lat_valid", 3, out_valid, 1'b1);
    check("lat_data", 3, out_data, 16'h0800);
    tick(2);
    outq.delete();

    // Vector table, streamed with a bubble after every fourth sample
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].mode, vecs[i].x);
      if (i % 4 == 3) tick(1);
      if (vecs[i].sat) exp_sat++;
    end
    wait_out(NV);
    for (int i = 0; i < NV; i++) begin
      check("table", i, (i < outq.size()) ? outq[i] : 16'hxxxx, vecs[i].exp);
    end
    tick(2);
    check("table_sat_cnt", 0, sat_cnt, exp_sat);

    // Backpressure: fill the pipe, stall 4 cycles, then drain
    outq.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(bp[i].mode, bp[i].x);
    in_valid = 1'b1;
    in_mode  = bp[3].mode;
    in_data  = bp[3].x;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_in_ready", k, in_ready, 1'b0);
      check("bp_out_valid", k, out_valid, 1'b1);
      check("bp_out_data", k, out_data, bp[0].exp);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 3; i < 6; i++) send(bp[i].mode, bp[i].x);
    wait_out(6);
    for (int i = 0; i < 6; i++) begin
      check("bp_order", i, (i < outq.size()) ? outq[i] : 16'hxxxx, bp[i].exp);
    end
    tick(4);
    check("bp_no_dup", 0, outq.size(), 6);

    // Reset with samples in flight
    outq.delete();
    send(1'b0, 32'h0600_0000);
    send(1'b0, 32'h0000_0000);
    send(1'b0, 32'h0100_0000);
    check("pre_rst_sat_cnt", 0, sat_cnt, exp_sat + 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 0, out_valid, 1'b0);
    check("mid_rst_sat_cnt", 0, sat_cnt, 6'd0);
    check("mid_rst_out_data", 0, out_data, 16'h0000);
    tick(1);
    rst = 1'b0;
    check("post_rst_in_ready", 0, in_ready, 1'b1);
    tick(6);
    check("post_rst_dropped", 0, outq.size(), 0);
    check("post_rst_out_valid", 0, out_valid, 1'b0);

    // sat_clr in the same cycle as an increment
    send(1'b0, 32'h0600_0000);
    send(1'b0, 32'h8000_0000);
    tick(1);
    check("clr_pre", 0, sat_cnt, 6'd1);
    sat_clr = 1'b1;
    tick(1);
    sat_clr = 1'b0;
    check("clr_priority", 0, sat_cnt, 6'd0);
    tick(4);
    outq.delete();

    // Counter saturates at all-ones
    for (int i = 0; i < 70; i++) send(1'b0, 32'h7FFF_FFFF);
    tick(5);
    check("cnt_saturate", 0, sat_cnt, 6'h3F);
    sat_clr = 1'b1;
    tick(1);
    sat_clr = 1'b0;
    check("cnt_clear", 0, sat_cnt, 6'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/plan_act.md
Name: plan_act

Overview:
- Parametrised, pipelined piecewise-linear activation unit. Successor to the single-cycle sigmoid PLAN block.
- Selectable mode per sample: sigmoid or tanh. Tanh is computed as 2*sigmoid(2x) - 1.
- Input/output fixed-point formats are generic. A valid/ready stream interface supports backpressure.
- Sits between accumulator outputs and the next layer's input buffer in the inference datapath.

Parameters:
- IN_W, 32, input width (two's complement; sign + integer + fraction)
- IN_FRAC, 24, input fraction bits; must satisfy IN_FRAC >= OUT_FRAC and IN_W - IN_FRAC >= 4
- OUT_W, 16, output width (two's complement)
- OUT_FRAC, 12, output fraction bits; must satisfy OUT_FRAC >= 5 and OUT_W - OUT_FRAC >= 2
- CNT_W, 16, width of the saturation counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  unit accepts the sample this cycle
- in_data  in  IN_W  signed input x
- in_mode  in  1  0 = sigmoid, 1 = tanh; sampled with in_data
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts the output
- out_data  out  OUT_W  signed result
- sat_cnt  out  CNT_W  count of accepted samples that landed in the saturation segment
- sat_clr  in  1  synchronous clear of sat_cnt

Behaviour:
- Pipeline control
  - Three register stages S1, S2, S3, with a per-stage valid bit.
  - Global enable: en = !out_valid || out_ready. All stages advance together when en = 1 and all hold when en = 0.
  - in_ready = en. A sample is accepted on a cycle where in_valid && in_ready.
  - Latency is 3 cycles from acceptance to out_valid with no stall. Throughput is 1 sample per cycle.
  - out_data and out_valid hold stable while out_valid && !out_ready.
- Reset: all valid bits, out_data, and sat_cnt go to 0. Reset asserted mid-stream drops all in-flight samples. in_ready is 1 the cycle after reset deasserts.
- S1 (magnitude)
  - Register sign = x[IN_W-1], the mode, and a magnitude a.
  - a = |x|. The most-negative input saturates to 2^(IN_W-1) - 1.
  - Tanh mode: a = 2|x|. If |x| >= 2^(IN_W-2), a saturates to 2^(IN_W-1) - 1.
- S2 (segment select)
  - Breakpoints 1.0, 2.375, 5.0, scaled by 2^IN_FRAC. Let t = a >> (IN_FRAC - OUT_FRAC), truncating.
  - a < 1.0: y = 0.5 + t>>2
  - 1.0 <= a < 2.375: y = 0.625 + t>>3
  - 2.375 <= a < 5.0: y = 0.84375 + t>>5
  - a >= 5.0: y = 1.0, and the sat flag is set.
  - Constants are scaled by 2^OUT_FRAC. Each breakpoint belongs to the upper segment. Shifts truncate toward zero.
- S3 (sign and mode)
  - s = sign ? (1.0 - y) : y.
  - Sigmoid: out_data = s, range [0, 1.0].
  - Tanh: out_data = 2s - 1.0, signed, range [-1.0, 1.0].
  - All arithmetic is at OUT_W bits with no overflow possible under the parameter constraints.
- sat_cnt
  - Increments by 1 when a sample with the sat flag advances from S2 to S3 (en && S2 valid && sat).
  - Saturates at all-ones; it does not wrap.
  - sat_clr has priority over an increment in the same cycle.
- Boundaries
  - in_valid = 0 inserts bubbles that propagate as valid = 0 and never alter sat_cnt.
  - Stall with a full pipeline: in_ready = 0, so no sample is lost or duplicated.
  - Simultaneous accept and output handshake in the same cycle is allowed.

Test Plan:
- Sigmoid mode, no stall, x = 0x00000000, 0x01000000, 0xFF000000, 0x03000000, 0x06000000 back-to-back -> out_data = 0x0800, 0x0C00, 0x0400, 0x0F00, 0x1000 on 5 consecutive cycles. The first result appears 3 cycles after acceptance, and sat_cnt = 1.
- Sigmoid mode, x = 0x80000000 (most negative) -> out_data = 0x0000 and sat_cnt increments. Breakpoint x = 0x02600000 -> 0.84375 + 0.07421875 truncated = 0x0EB0.
- Tanh mode, x = 0x00800000 (0.5) -> 0x0800; x = 0xFF800000 (-0.5) -> 0xF800; x = 0 -> 0x0000; x = 0x7FFFFFFF -> 0x1000.
- Mixed mode per cycle, alternating sigmoid/tanh with x = 0x00800000 -> 0x0A00, 0x0800, 0x0A00, ... in order, with no cross-sample mode leakage.
- Backpressure: feed 6 samples and hold out_ready = 0 for 4 cycles -> in_ready drops once the pipeline is full, out_data stays stable, and all 6 results arrive in order with none lost or duplicated.
- Assert rst with 3 samples in flight -> out_valid = 0 and sat_cnt = 0 immediately. Release reset -> in_ready = 1. Separately, sat_clr in the same cycle as a sat increment -> sat_cnt = 0. Driving sat_cnt to all-ones -> it holds at all-ones.
